// File: rtl/dm_lane.sv
// dm_lane: byte-lane data memory with sized, extended loads/stores; define DM_LANE_SPLIT_EN to complete row-crossing accesses in two cycles
module dm_lane #(
  parameter int DEPTH = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = AW - 2;
  localparam int ROWS = DEPTH / 4;
  logic split, accept, start, done, we, uns, crossing, err, unused_addr;
  logic [1:0] size, off;
  logic [5:0] sh;
  logic [RW-1:0] row;
  logic [RW-1:0] lane_row [4];
  logic [31:0] wdata, wrot, rd_all, rd_merged, d, ext;
  logic [3:0] bmask, lmask, fm, lane_we;
  assign unused_addr = ^req_addr[31:AW];
`ifdef DM_LANE_SPLIT_EN
  typedef enum logic {IDLE, SPLIT} state_t;
  state_t state;
  logic s_we, s_uns;
  logic [1:0] s_size, s_off;
  logic [RW-1:0] s_row;
  logic [31:0] s_wdata, s_rd, fm32;
  assign split = state == SPLIT;
  assign req_ready = !split;
  assign we = split ? s_we : req_we;
  assign uns = split ? s_uns : req_unsigned;
  assign size = split ? s_size : req_size;
  assign off = split ? s_off : req_addr[1:0];
  assign row = split ? s_row : req_addr[AW-1:2];
  assign wdata = split ? s_wdata : req_wdata;
  assign start = accept && crossing;
  assign err = size == 2'd3;
  assign fm32 = {{8{fm[3]}}, {8{fm[2]}}, {8{fm[1]}}, {8{fm[0]}}};
  // lanes at or above the offset came from the first row in the previous cycle
  assign rd_merged = split ? (s_rd & fm32) | (rd_all & ~fm32) : rd_all;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= start ? SPLIT : IDLE;
  always_ff @(posedge clk)
    if (start) begin
      s_we <= req_we;
      s_uns <= req_unsigned;
      s_size <= req_size;
      s_off <= req_addr[1:0];
      s_row <= req_addr[AW-1:2];
      s_wdata <= req_wdata;
      s_rd <= rd_all;
    end
`else
  assign split = 1'b0;
  assign req_ready = 1'b1;
  assign we = req_we;
  assign uns = req_unsigned;
  assign size = req_size;
  assign off = req_addr[1:0];
  assign row = req_addr[AW-1:2];
  assign wdata = req_wdata;
  assign start = 1'b0;
  assign err = size == 2'd3 || crossing;
  assign rd_merged = rd_all;
`endif
  assign accept = req_valid && req_ready;
  assign done = split || (accept && !start);
  assign crossing = (size == 2'd1 && off == 2'd3) || (size == 2'd2 && off != 2'd0);
  assign bmask = size == 2'd0 ? 4'b0001 : size == 2'd1 ? 4'b0011 : size == 2'd2 ? 4'b1111 : 4'b0000;
  assign lmask = (bmask << off) | (bmask >> (3'd4 - {1'b0, off}));
  assign fm = 4'b1111 << off;
  assign sh = {1'b0, off, 3'b000};
  assign wrot = (wdata << sh) | (wdata >> (6'd32 - sh));
  assign d = (rd_merged >> sh) | (rd_merged << (6'd32 - sh));
  assign ext = size == 2'd0 ? {{24{!uns && d[7]}}, d[7:0]} :
               size == 2'd1 ? {{16{!uns && d[15]}}, d[15:0]} : d;
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] ram [ROWS];
    assign lane_row[i] = fm[i] ? row : row + RW'(1);
    assign lane_we[i] = rst_n && (split || accept) && we && !err && lmask[i] && (split ? !fm[i] : fm[i]);
    assign rd_all[8*i +: 8] = ram[lane_row[i]];
    always_ff @(posedge clk)
      if (lane_we[i]) ram[lane_row[i]] <= wrot[8*i +: 8];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= done;
      rsp_err <= done && err;
      rsp_rdata <= done && !err && !we ? ext : '0;
    end
endmodule
